// File: rtl/aabb_hit_resolver_pkg.sv
// Shared definitions for the ray/box slab-test back end: FP format, exception codes, default latency.
// Optional hit counter in aabb_hit_resolver is enabled by defining AABB_HIT_COUNT_EN.
package aabb_hit_resolver_pkg;

   localparam int FP_WE = 11;
   localparam int FP_WF = 1;
   localparam int FP_W  = 15;

   typedef enum logic [1:0] {
      EXC_ZERO   = 2'b00,
      EXC_NORMAL = 2'b01,
      EXC_INF    = 2'b10,
      EXC_NAN    = 2'b11
   } fp_exc_e;

   // Shared with the comparator instantiations so tag delay and flag latency stay in step.
   localparam int CMP_LAT_DEF    = 4;
   localparam int TAG_W_DEF      = 8;
   localparam int FIFO_DEPTH_DEF = 16;
   localparam int CNT_W_DEF      = 16;

   function automatic logic resolve_hit(input logic gt_min_max, input logic gt_zero_max);
      return ~gt_min_max & ~gt_zero_max;
   endfunction

endpackage

// File: rtl/aabb_result_fifo.sv
// Result buffer for aabb_hit_resolver: power-of-two depth, registered count, no bypass path.
module aabb_result_fifo
   import aabb_hit_resolver_pkg::*;
#(
   parameter int W     = 9,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A push at full is only taken when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/aabb_hit_resolver.sv
// Aligns ray/box tags with the slab comparator flags, resolves hit, and buffers results with credit flow control.
// Define AABB_HIT_COUNT_EN to build the saturating delivered-hit counter; otherwise hit_count reads 0.
module aabb_hit_resolver
   import aabb_hit_resolver_pkg::*;
#(
   parameter int CMP_LAT    = CMP_LAT_DEF,
   parameter int TAG_W      = TAG_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             in_ready,
   input  logic             gt_min_max,
   input  logic             gt_zero_max,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output logic [TAG_W-1:0] out_tag,
   output logic             err_drop,
   output logic [CNT_W-1:0] hit_count
);

   localparam int CW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

   logic               accept;
   logic [CMP_LAT-1:0] vld_p;
   logic [TAG_W-1:0]   tag_p [CMP_LAT];
   logic [CW:0]        inflight;
   logic [CW:0]        fifo_count;
   logic [CW:0]        occ;
   logic               res_push;
   logic               res_hit;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [TAG_W:0]     fifo_dout;

   assign accept   = in_valid && in_ready;
   // Occupancy counts results already buffered plus those still in the comparators.
   assign occ      = fifo_count + inflight;
   assign in_ready = !fifo_full && (occ < DEPTH_V);

   // Delay line stage boundary: valid bits are control and reset, tags are data and do not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i < CMP_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_p[0] <= in_tag;
      for (int i = 1; i < CMP_LAT; i++) tag_p[i] <= tag_p[i-1];
   end

   assign res_push = vld_p[CMP_LAT-1];
   assign res_hit  = resolve_hit(gt_min_max, gt_zero_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({accept, res_push})
            2'b10:   inflight <= inflight + (CW+1)'(1);
            2'b01:   inflight <= inflight - (CW+1)'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Result buffer stage boundary.
   aabb_result_fifo #(
      .W     (TAG_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_push),
      .din   ({res_hit, tag_p[CMP_LAT-1]}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;
   // Unreset FIFO storage is masked so the outputs read 0 whenever nothing is valid.
   assign out_hit   = out_valid & fifo_dout[TAG_W];
   assign out_tag   = out_valid ? fifo_dout[TAG_W-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      err_drop <= 1'b0;
      else if (in_valid && !in_ready) err_drop <= 1'b1;
   end

`ifdef AABB_HIT_COUNT_EN
   logic [CNT_W-1:0] hit_count_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    hit_count_r <= '0;
      else if (fifo_pop && out_hit) hit_count_r <= sat_inc(hit_count_r);
   end

   assign hit_count = hit_count_r;
`else
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_aabb_hit_resolver.sv
// Randomized self-checking bench for aabb_hit_resolver against a queue-based transaction model.
module tb_aabb_hit_resolver;

   localparam int CMP_LAT    = 4;
   localparam int TAG_W      = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 16;
   localparam int SZ         = 4096;
`ifdef AABB_HIT_COUNT_EN
   localparam bit HC_EN = 1'b1;
`else
   localparam bit HC_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             in_ready;
   logic             gt_min_max = 1'b0;
   logic             gt_zero_max = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_hit;
   logic [TAG_W-1:0] out_tag;
   logic             err_drop;
   logic [CNT_W-1:0] hit_count;

   aabb_hit_resolver #(
      .CMP_LAT(CMP_LAT), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
      .gt_min_max(gt_min_max), .gt_zero_max(gt_zero_max), .out_valid(out_valid),
      .out_ready(out_ready), .out_hit(out_hit), .out_tag(out_tag), .err_drop(err_drop),
      .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               hit;
      logic [TAG_W-1:0] tag;
      int               rdy;
   } res_t;

   res_t             q[$];
   int               outstanding = 0;
   bit               err_m = 1'b0;
   logic [CNT_W-1:0] hc_m = '0;
   bit               sch_mm [SZ];
   bit               sch_zm [SZ];
   int               cyc = 0;
   int               n_chk = 0;
   int               n_fail = 0;
   bit               last_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock of stimulus: drive after the edge, check at the falling edge, then advance the model.
   task automatic step(input bit iv, input logic [TAG_W-1:0] tg, input bit mm, input bit zm,
                       input bit ordy, input bit do_rst);
      bit   exp_rdy, exp_ov;
      @(posedge clk);
      #1;
      rst         = do_rst;
      in_valid    = iv && !do_rst;
      in_tag      = tg;
      gt_min_max  = sch_mm[cyc % SZ];
      gt_zero_max = sch_zm[cyc % SZ];
      out_ready   = ordy;
      if (do_rst) begin
         q.delete();
         outstanding = 0;
         err_m = 1'b0;
         hc_m = '0;
      end
      @(negedge clk);
      exp_rdy = (outstanding < FIFO_DEPTH);
      exp_ov  = (q.size() > 0) && (q[0].rdy <= cyc);
      last_rdy = in_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_hit", 32'(out_hit), exp_ov ? 32'(q[0].hit) : 32'd0);
      chk("out_tag", 32'(out_tag), exp_ov ? 32'(q[0].tag) : 32'd0);
      chk("err_drop", 32'(err_drop), 32'(err_m));
      chk("hit_count", 32'(hit_count), HC_EN ? 32'(hc_m) : 32'd0);
      if (exp_ov && ordy) begin
         if (q[0].hit && hc_m != '1) hc_m++;
         void'(q.pop_front());
         outstanding--;
      end
      if (in_valid) begin
         if (exp_rdy) begin
            q.push_back('{hit: !(mm || zm), tag: tg, rdy: cyc + CMP_LAT + 1});
            outstanding++;
            sch_mm[(cyc + CMP_LAT) % SZ] = mm;
            sch_zm[(cyc + CMP_LAT) % SZ] = zm;
         end else begin
            err_m = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 1'b0, ordy, 1'b0);
   endtask

   int n_acc;
   int first_out;

   initial begin
      // Unissued cycles carry random flags that must be ignored.
      for (int i = 0; i < SZ; i++) begin
         sch_mm[i] = 1'($urandom);
         sch_zm[i] = 1'($urandom);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Single op with explicit latency check.
      step(1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
      first_out = -1;
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
         if (out_valid && first_out < 0) first_out = i;
      end
      chk("single_latency", 32'(first_out), 32'(CMP_LAT + 1));

      // Miss cases.
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(8, 1'b1);

      // Back-to-back stream with alternating flag patterns.
      for (int i = 0; i < 40; i++)
         step(1'b1, 8'(8'h40 + i), i[0], i[1], 1'b1, 1'b0);
      idle(8, 1'b1);

      // Backpressure: fill to the credit limit, then violate once.
      n_acc = 0;
      for (int i = 0; i < 25; i++) begin
         step(outstanding < FIFO_DEPTH, 8'(8'h80 + i), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
         if (in_valid && last_rdy) n_acc++;
      end
      chk("bp_accepts", 32'(n_acc), 32'(FIFO_DEPTH));
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("err_sticky", 32'(err_drop), 32'd1);
      idle(FIFO_DEPTH + 4, 1'b1);
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Random traffic with random consumer stalls.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0) && (outstanding < FIFO_DEPTH), 8'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), 1'b0);
      idle(FIFO_DEPTH + 8, 1'b1);

      // Reset mid-flight: stale flags must produce nothing.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      idle(10, 1'b1);

      // Hit counting: 10 results, 7 hits.
      for (int i = 0; i < 10; i++)
         step(1'b1, 8'(8'hD0 + i), (i >= 7) && i[0], (i >= 7) && !i[0], 1'b1, 1'b0);
      idle(10, 1'b1);
      chk("hit_count_final", 32'(hit_count), HC_EN ? 32'd7 : 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aabb_hit_resolver.md
Name: aabb_hit_resolver

Overview:
- Downstream stage of the two slab-test FP comparators, each of which emits a registered 1-bit "A greater than B" flag.
  - Comparator 0 computes tmin > tmax.
  - Comparator 1 computes 0 > tmax.
- Delays each accepted ray/box tag by the comparator latency so tag and flags line up, then resolves hit = !gt_min_max && !gt_zero_max.
- Buffers results in a small FIFO with ready/valid output and credit-based input flow control, because the comparator pipeline cannot stall.

Parameters:
- CMP_LAT, 4: cycles from operands at the comparator inputs to a valid greater flag (FP subtract latency + 1 register).
- TAG_W, 8: width of the ray/box identifier.
- FIFO_DEPTH, 16: result FIFO entries; power of two, must be > CMP_LAT+1.
- CNT_W, 16: hit counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands presented to both comparators this cycle
- in_tag  in  TAG_W  id of those operands
- in_ready  out  1  upstream may assert in_valid
- gt_min_max  in  1  comparator 0 flag (tmin > tmax), CMP_LAT cycles after issue
- gt_zero_max  in  1  comparator 1 flag (0 > tmax), CMP_LAT cycles after issue
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_hit  out  1  1 = ray intersects box
- out_tag  out  TAG_W  tag of result
- err_drop  out  1  sticky: in_valid seen while in_ready=0
- hit_count  out  CNT_W  hits delivered (optional feature)

Behaviour:
- Reset values:
  - in_ready=1.
  - out_valid=0, out_hit=0, out_tag=0.
  - err_drop=0, hit_count=0.
  - Delay line and FIFO emptied.
- Accept rule:
  - accept = in_valid && in_ready.
  - in_valid with in_ready=0 is ignored and sets err_drop, which stays set until rst.
- Delay line: CMP_LAT-stage shift register of {valid, tag}.
  - Shifts every cycle and never stalls.
  - Stage 0 loads {accept, in_tag}.
- Resolve (combinational, from the last delay stage):
  - Active when the last stage's valid is 1.
  - hit = ~gt_min_max & ~gt_zero_max, sampled in the same cycle as the last stage.
  - {hit, tag} is pushed into the FIFO that cycle.
  - Flags are ignored when the last stage's valid is 0.
- In-flight count: inflight = number of set valid bits in the delay line, kept as a counter.
  - +1 on accept.
  - -1 when the last stage pushes.
  - Both events in the same cycle leave it unchanged.
- Credit rule:
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH, computed combinationally from registered counters.
  - Guarantees no push into a full FIFO.
- FIFO output:
  - out_valid = !empty; {out_hit, out_tag} = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged, including at full and at empty (an empty FIFO with a push shows out_valid on the next cycle; no bypass).
- Latency: accept in cycle t gives out_valid at t+CMP_LAT+1 when the FIFO is empty.
- Ordering: strictly in order; every accepted input yields exactly one output.
- Pointers wrap modulo FIFO_DEPTH; the count field is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-operation:
  - All in-flight and buffered results are discarded.
  - Comparator flags still in flight are ignored because all valid bits are cleared.
- NaN/infinity operands: comparator flags read 0, so the result resolves to hit=1. Rejecting such cases is the upstream stage's job and is not handled here.

Optional Feature:
- Macro: AABB_HIT_COUNT_EN.
- Defined:
  - hit_count increments on each pop with out_hit=1.
  - Saturates at all-ones.
  - Cleared only by rst.
- Undefined: the counter logic is absent and hit_count is tied to 0.
- The port exists in both builds.

Decomposition:
- Shared include (raabb_defs.vh) holds:
  - FP format constants: WE=11, WF=1, total width 15.
  - Exception-field encodings: 00 zero, 01 normal, 10 inf, 11 NaN.
  - Default CMP_LAT, shared with the comparator instantiations.
- One sub-module: aabb_result_fifo.
  - Parameterised width and depth.
  - Exposes count; push/pop/full/empty.

Test Plan:
- Single op: tag 0x2A, flags 0/0 at t+4 → out_valid at t+5, out_hit=1, out_tag=0x2A.
- Miss cases: tags 1, 2, 3 with flags (1,0), (0,1), (1,1) → out_hit=0, 0, 0, in tag order.
- Back-to-back stream: 40 consecutive accepts with alternating flag patterns, out_ready=1 → 40 outputs, in order, one per cycle after initial latency.
- Backpressure: out_ready=0 while issuing.
  - in_ready drops after exactly 16 accepts; FIFO never overflows.
  - Forcing in_valid one cycle while in_ready=0 sets err_drop=1.
  - Releasing out_ready drains all 16 entries.
- Reset mid-flight: 3 accepts, rst pulsed 2 cycles later → no outputs; in_ready=1, out_valid=0 immediately; stale flags arriving afterwards produce nothing.
- AABB_HIT_COUNT_EN: 10 results, 7 hits, popped → hit_count=7; with the macro undefined, hit_count=0.
